// File: rtl/axis_spi_reg_pkg.sv
//------------------------------------------------------------------------------
// Module : axis_spi_reg_pkg
// Brief  : Command codes, FSM state encoding and fill byte for the SPI
//          register bridge.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package axis_spi_reg_pkg;

    localparam logic [7:0] CMD_WRITE    = 8'h01;
    localparam logic [7:0] CMD_READ     = 8'h02;
    localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_WR_DATA = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_WAIT = 3'd4,
        S_RD_DATA = 3'd5,
        S_DISCARD = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/axis_spi_reg_bridge.sv
//------------------------------------------------------------------------------
// Module : axis_spi_reg_bridge
// Brief  : Decodes an SPI byte stream into register writes and reads with
//          address auto-increment; read data returns as a byte stream.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axis_spi_reg_bridge #(
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    output logic [7:0]            output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [7:0]            reg_wr_data,
    output logic                  reg_wr_en,
    output logic                  reg_rd_en,
    input  logic [7:0]            reg_rd_data,
    input  logic                  reg_rd_ack,
    output logic                  busy,
    output logic                  rd_timeout
);

    import axis_spi_reg_pkg::*;

    localparam int CNT_W = (READ_TIMEOUT > 0) ? $clog2(READ_TIMEOUT + 1) : 1;

    state_t           r_state;
    state_t           w_next;
    logic             r_started;
    logic             r_is_read;
    logic             r_last_pend;
    logic [CNT_W-1:0] r_cnt;

    logic w_accept;
    logic w_waiting;
    logic w_ack_hit;
    logic w_timeout_hit;
    logic w_rd_done;

    assign input_axis_tready = r_started && (r_state != S_RD_REQ) && (r_state != S_RD_WAIT);
    assign w_accept          = input_axis_tvalid && input_axis_tready;
    assign w_waiting         = (r_state == S_RD_REQ) || (r_state == S_RD_WAIT);
    assign w_ack_hit         = w_waiting && reg_rd_ack;
    assign w_timeout_hit     = w_waiting && !reg_rd_ack && (r_cnt == CNT_W'(READ_TIMEOUT));
    assign w_rd_done         = w_ack_hit || w_timeout_hit;
    assign reg_rd_en         = (r_state == S_RD_REQ);
    assign busy              = (r_state != S_IDLE);
    assign output_axis_tlast = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !input_axis_tlast) begin
                    if (input_axis_tdata == CMD_WRITE || input_axis_tdata == CMD_READ) begin
                        w_next = S_ADDR;
                    end else begin
                        w_next = S_DISCARD;
                    end
                end
            end
            S_ADDR: begin
                // A read still issues its request when the address byte ends the frame
                if (w_accept) begin
                    if (r_is_read) begin
                        w_next = S_RD_REQ;
                    end else if (input_axis_tlast) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_WR_DATA;
                    end
                end
            end
            S_WR_DATA: begin
                if (w_accept && input_axis_tlast) begin
                    w_next = S_IDLE;
                end
            end
            S_RD_REQ, S_RD_WAIT: begin
                if (w_rd_done) begin
                    w_next = r_last_pend ? S_IDLE : S_RD_DATA;
                end else begin
                    w_next = S_RD_WAIT;
                end
            end
            S_RD_DATA: begin
                if (w_accept) begin
                    w_next = S_RD_REQ;
                end
            end
            S_DISCARD: begin
                if (w_accept && input_axis_tlast) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_started          <= 1'b0;
            r_is_read          <= 1'b0;
            r_last_pend        <= 1'b0;
            r_cnt              <= '0;
            reg_addr           <= '0;
            reg_wr_data        <= 8'h00;
            reg_wr_en          <= 1'b0;
            output_axis_tdata  <= 8'h00;
            output_axis_tvalid <= 1'b0;
            rd_timeout         <= 1'b0;
        end else begin
            r_started  <= 1'b1;
            reg_wr_en  <= 1'b0;
            rd_timeout <= w_timeout_hit;

            if (r_state == S_IDLE && w_accept) begin
                r_is_read <= (input_axis_tdata == CMD_READ);
            end
            if (w_accept && (r_state == S_ADDR || r_state == S_RD_DATA)) begin
                r_last_pend <= input_axis_tlast;
            end

            if (r_state == S_WR_DATA && w_accept) begin
                reg_wr_data <= input_axis_tdata;
                reg_wr_en   <= 1'b1;
            end

            // Writes advance the address after their strobe; reads advance before the prefetch
            if (r_state == S_ADDR && w_accept) begin
                reg_addr <= ADDR_WIDTH'(input_axis_tdata);
            end else if (reg_wr_en || (r_state == S_RD_DATA && w_accept)) begin
                reg_addr <= reg_addr + ADDR_WIDTH'(1);
            end

            if (w_waiting && !w_rd_done) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end

            if (w_next == S_IDLE) begin
                output_axis_tvalid <= 1'b0;
            end else if (w_rd_done) begin
                output_axis_tdata  <= w_ack_hit ? reg_rd_data : TIMEOUT_FILL;
                output_axis_tvalid <= 1'b1;
            end else if (output_axis_tready) begin
                output_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_spi_reg_bridge.sv
//------------------------------------------------------------------------------
// Module : tb_axis_spi_reg_bridge
// Brief  : Directed self-checking bench for axis_spi_reg_bridge.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_axis_spi_reg_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
    logic [7:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] resp_data = 8'h00;
    logic       resp_ack = 1'b0;
    logic       manual_ack = 1'b0;
    logic       busy;
    logic       rd_timeout;

    axis_spi_reg_bridge #(.ADDR_WIDTH(8), .READ_TIMEOUT(255)) dut (
        .clk                (clk),
        .rst                (rst),
        .input_axis_tdata   (in_data),
        .input_axis_tvalid  (in_valid),
        .input_axis_tready  (in_ready),
        .input_axis_tlast   (in_last),
        .output_axis_tdata  (out_data),
        .output_axis_tvalid (out_valid),
        .output_axis_tready (out_ready),
        .output_axis_tlast  (out_last),
        .reg_addr           (reg_addr),
        .reg_wr_data        (reg_wr_data),
        .reg_wr_en          (reg_wr_en),
        .reg_rd_en          (reg_rd_en),
        .reg_rd_data        (resp_data),
        .reg_rd_ack         (resp_ack | manual_ack),
        .busy               (busy),
        .rd_timeout         (rd_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = -1;
    int hs_cyc = 0;
    int wr_cyc = 0;
    int rd_cyc = 0;
    int out_cyc = 0;
    int tmo_cyc = 0;
    int tmo_cnt = 0;
    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  out_q[$];
    logic [7:0]  mem[256];
    logic        pend = 1'b0;
    int          pcnt = 0;
    logic [7:0]  paddr = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor plus register responder with programmable ack latency
    always @(negedge clk) begin
        if (reg_wr_en) begin wr_q.push_back({reg_addr, reg_wr_data}); wr_cyc = cyc; end
        if (reg_rd_en) begin rd_q.push_back(reg_addr); rd_cyc = cyc; end
        if (out_valid && out_ready) begin out_q.push_back(out_data); out_cyc = cyc; end
        if (rd_timeout) begin tmo_cnt++; tmo_cyc = cyc; end
        resp_ack = 1'b0;
        if (reg_rd_en && lat >= 0) begin pend = 1'b1; pcnt = lat; paddr = reg_addr; end
        if (pend) begin
            if (pcnt == 0) begin
                resp_ack = 1'b1; resp_data = mem[paddr]; pend = 1'b0;
            end else begin
                pcnt--;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int guard = 0;
        in_data = d; in_last = l; in_valid = 1'b1;
        while (!in_ready && guard < 1000) begin @(negedge clk); guard++; end
        check("handshake_bound", 32'(guard < 1000), 32'd1);
        @(negedge clk);
        hs_cyc = cyc;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        wr_q.delete(); rd_q.delete(); out_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5C);
        mem[8'h20] = 8'h5A; mem[8'h21] = 8'hC3; mem[8'h22] = 8'h77;
        mem[8'h40] = 8'hA5; mem[8'h60] = 8'h3C;

        // Reset state
        wait_cycles(3);
        check("rst_tready", 32'(in_ready), 32'd0);
        check("rst_tvalid", 32'(out_valid), 32'd0);
        check("rst_tdata", 32'(out_data), 32'd0);
        check("rst_tlast", 32'(out_last), 32'd0);
        check("rst_addr", 32'(reg_addr), 32'd0);
        check("rst_wr_data", 32'(reg_wr_data), 32'd0);
        check("rst_strobes", {30'd0, reg_wr_en, reg_rd_en}, 32'd0);
        check("rst_busy_tmo", {30'd0, busy, rd_timeout}, 32'd0);
        rst = 1'b0;
        check("tready_at_release", 32'(in_ready), 32'd0);
        wait_cycles(1);
        check("tready_after_release", 32'(in_ready), 32'd1);

        // Write frame with auto-increment
        clear_logs();
        send_byte(8'h01, 1'b0); send_byte(8'h10, 1'b0);
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b1);
        wait_cycles(3);
        check("wr_count", 32'(wr_q.size()), 32'd2);
        check("wr0", 32'(wr_q[0]), 32'h10AA);
        check("wr1", 32'(wr_q[1]), 32'h11BB);
        check("wr_strobe_timing", 32'(wr_cyc), 32'(hs_cyc));
        check("wr_no_reads", 32'(rd_q.size()), 32'd0);
        check("wr_busy_end", 32'(busy), 32'd0);

        // Read frame, ack latency 3
        clear_logs(); lat = 3;
        send_byte(8'h02, 1'b0); send_byte(8'h20, 1'b0);
        wait_cycles(1);
        check("rd_req_timing", 32'(rd_cyc), 32'(hs_cyc));
        wait_cycles(5);
        check("rd_first_latency", 32'(out_cyc), 32'(rd_cyc + 4));
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b1);
        wait_cycles(8);
        check("rd_out_count", 32'(out_q.size()), 32'd2);
        check("rd_out0", 32'(out_q[0]), 32'h5A);
        check("rd_out1", 32'(out_q[1]), 32'hC3);
        check("rd_req_count", 32'(rd_q.size()), 32'd3);
        check("rd_req_addrs", {8'd0, rd_q[0], rd_q[1], rd_q[2]}, 32'h00202122);
        check("rd_tvalid_end", 32'(out_valid), 32'd0);
        check("rd_busy_end", 32'(busy), 32'd0);

        // Held output byte is dropped at frame end
        clear_logs(); lat = 1; out_ready = 1'b0;
        send_byte(8'h02, 1'b0); send_byte(8'h40, 1'b0);
        wait_cycles(5);
        check("hold_tvalid", 32'(out_valid), 32'd1);
        check("hold_tdata", 32'(out_data), 32'hA5);
        send_byte(8'h00, 1'b1);
        wait_cycles(5);
        check("hold_cleared", 32'(out_valid), 32'd0);
        check("hold_busy_end", 32'(busy), 32'd0);
        out_ready = 1'b1;

        // Ack in the same cycle as reg_rd_en
        clear_logs(); lat = 0;
        send_byte(8'h02, 1'b0); send_byte(8'h60, 1'b0);
        wait_cycles(3);
        check("ack0_latency", 32'(out_cyc), 32'(rd_cyc + 1));
        check("ack0_data", 32'(out_q[0]), 32'h3C);
        send_byte(8'h00, 1'b1);
        wait_cycles(4);

        // Read timeout
        clear_logs(); lat = -1; tmo_cnt = 0;
        send_byte(8'h02, 1'b0); send_byte(8'h50, 1'b0);
        wait_cycles(262);
        check("tmo_pulses", 32'(tmo_cnt), 32'd1);
        check("tmo_cycle", 32'(tmo_cyc), 32'(rd_cyc + 256));
        check("tmo_out_cycle", 32'(out_cyc), 32'(rd_cyc + 256));
        check("tmo_fill", 32'(out_q[0]), 32'hFF);
        send_byte(8'h00, 1'b1);
        wait_cycles(262);
        check("tmo_busy_end", 32'(busy), 32'd0);

        // Unknown command then a normal write
        clear_logs();
        send_byte(8'h7E, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b1);
        wait_cycles(3);
        check("unk_no_writes", 32'(wr_q.size()), 32'd0);
        check("unk_no_reads", 32'(rd_q.size()), 32'd0);
        check("unk_busy_end", 32'(busy), 32'd0);
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h11, 1'b1);
        wait_cycles(3);
        check("unk_next_count", 32'(wr_q.size()), 32'd1);
        check("unk_next_wr", 32'(wr_q[0]), 32'h0011);

        // Address wrap
        clear_logs();
        send_byte(8'h01, 1'b0); send_byte(8'hFF, 1'b0);
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b1);
        wait_cycles(3);
        check("wrap_count", 32'(wr_q.size()), 32'd2);
        check("wrap0", 32'(wr_q[0]), 32'hFF01);
        check("wrap1", 32'(wr_q[1]), 32'h0002);

        // Reset during RD_WAIT, then a late ack
        clear_logs(); lat = -1; tmo_cnt = 0;
        send_byte(8'h02, 1'b0); send_byte(8'h70, 1'b0);
        wait_cycles(5);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_tready", 32'(in_ready), 32'd0);
        check("mid_rst_addr", 32'(reg_addr), 32'd0);
        check("mid_rst_outs", {29'd0, reg_rd_en, out_valid, rd_timeout}, 32'd0);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(1);
        manual_ack = 1'b1;
        wait_cycles(1);
        manual_ack = 1'b0;
        wait_cycles(5);
        check("late_ack_tvalid", 32'(out_valid), 32'd0);
        check("late_ack_no_out", 32'(out_q.size()), 32'd0);
        check("late_ack_busy", 32'(busy), 32'd0);
        check("late_ack_no_tmo", 32'(tmo_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axis_spi_reg_bridge.md
# axis_spi_reg_bridge

Byte-stream command parser that sits directly downstream of the AXI4-Stream SPI slave. It consumes received SPI bytes, with tlast marking chip-select release, and decodes them into single-cycle register writes and handshaked register reads on a simple local register bus. Read data is returned as a byte stream that feeds the SPI slave's transmit input, so a master can read and write FPGA control registers over one SPI frame with address auto-increment.

## Interface
- ADDR_WIDTH, 8: register address width; the address byte is zero-extended or truncated to this width.
- READ_TIMEOUT, 255: clk cycles to wait for reg_rd_ack before substituting 0xFF.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- input_axis_tdata  in  8  received SPI byte (from SPI slave output stream).
- input_axis_tvalid  in  1  received byte valid.
- input_axis_tready  out  1  bridge can accept a byte.
- input_axis_tlast  in  1  last byte of SPI frame.
- output_axis_tdata  out  8  byte to transmit (to SPI slave input stream).
- output_axis_tvalid  out  1  transmit byte valid.
- output_axis_tready  in  1  SPI slave took the byte.
- output_axis_tlast  out  1  always 0.
- reg_addr  out  ADDR_WIDTH  register address.
- reg_wr_data  out  8  write data.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_rd_en  out  1  one-cycle read request.
- reg_rd_data  in  8  read data, valid with reg_rd_ack.
- reg_rd_ack  in  1  read completion.
- busy  out  1  frame in progress (state != IDLE).
- rd_timeout  out  1  one-cycle pulse when a read times out.

## Operation
- Frame format: byte0 = command, byte1 = start address, then data bytes. Commands: 0x01 WRITE, 0x02 READ. Any other value is an unknown command.
- States:
  - IDLE: wait for the command byte.
  - ADDR: wait for the address byte.
  - WR_DATA: receive write data.
  - RD_REQ: issue reg_rd_en.
  - RD_WAIT: wait for reg_rd_ack or timeout.
  - RD_DATA: wait for the next dummy byte.
  - DISCARD: ignore bytes until tlast.
- Any accepted byte with tlast=1 returns to IDLE after that byte's action completes. This takes priority over all other transitions except a pending read: RD_REQ/RD_WAIT finish the read first, then go to IDLE.
- IDLE:
  - 0x01 → ADDR (write).
  - 0x02 → ADDR (read).
  - Other value → DISCARD.
  - A byte with tlast → stay in IDLE, no action.
- ADDR: latch the address into reg_addr; go to WR_DATA for a write, RD_REQ for a read.
- WR_DATA: each byte → reg_wr_data = byte, reg_wr_en pulse at the current reg_addr. reg_addr increments the cycle after the strobe and wraps modulo 2^ADDR_WIDTH.
- RD_REQ: reg_rd_en pulse at reg_addr → RD_WAIT.
- RD_WAIT:
  - On reg_rd_ack: load reg_rd_data into the output register, tvalid=1 → RD_DATA.
  - On timeout: load 0xFF, pulse rd_timeout → RD_DATA.
- RD_DATA: each accepted dummy byte → reg_addr+1 → RD_REQ, which prefetches the next register.
- input_axis_tready = 0 in RD_REQ and RD_WAIT; 1 in every other state. A byte that the upstream slave drops while tready=0 is lost; this is accepted behaviour.
- Output register:
  - Holds one byte.
  - tvalid clears when output_axis_tready is sampled high.
  - A new load while the register is still valid overwrites it.
  - Entering IDLE (frame end) clears tvalid, so stale read data is never sent in the next frame.
- Reset mid-frame: all state and outputs return to reset values immediately; no strobes are emitted.

## Timing
- Reset values: input_axis_tready=0, output_axis_tdata=0, output_axis_tvalid=0, output_axis_tlast=0, reg_addr=0, reg_wr_data=0, reg_wr_en=0, reg_rd_en=0, busy=0, rd_timeout=0. input_axis_tready goes to 1 the first cycle after reset release.
- Write: reg_wr_en is asserted in cycle N+1 for a data byte handshaked in cycle N.
- Read request: reg_rd_en is asserted in cycle N+1 for an address or dummy byte handshaked in cycle N.
- Read return: reg_rd_ack sampled in cycle M → output_axis_tvalid=1 in cycle M+1.
- Ack in the same cycle as reg_rd_en is legal and is sampled.
- Timeout counter starts at 0 in the reg_rd_en cycle and fires when the count reaches READ_TIMEOUT. An ack arriving in the same cycle as the timeout wins, and rd_timeout does not pulse.
- reg_rd_ack outside RD_WAIT is ignored.

## Structure
- Package axis_spi_reg_pkg holds CMD_WRITE=8'h01, CMD_READ=8'h02, the state encoding, and the timeout fill byte 8'hFF.
- No sub-module: a single FSM with address, output and timeout registers.

## Test plan
- Write frame 01 10 AA BB (tlast on BB) → reg_wr_en with (0x10, 0xAA) then (0x11, 0xBB); bridge returns to IDLE and busy=0.
- Read frame 02 20 00 00 (tlast on last), ack latency 3 cycles, reg 0x20=0x5A and 0x21=0xC3 → output bytes 0x5A then 0xC3; reg_rd_en at 0x20, 0x21 and 0x22; after tlast, tvalid=0.
- Read with no ack → 0xFF output after READ_TIMEOUT cycles, rd_timeout pulses once.
- Unknown command 0x7E followed by 3 bytes → no reg strobes; IDLE after tlast; the next frame 01 00 11 writes 0x11 to address 0x00.
- Address wrap: ADDR_WIDTH=8, frame 01 FF 01 02 → writes at 0xFF then 0x00.
- Assert rst during RD_WAIT → all outputs return to reset values in the same cycle; a late reg_rd_ack after reset release produces no output.
